// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Drives a 4-bit word onto a 4:1 bit multiplexer and walks the select
// through all four positions. It dwells HOLD_CYCLES cycles on each position,
// samples the mux output, streams every sampled bit, and then presents the
// reassembled word. The error flag is set when the reassembled word differs
// from the word that was driven.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data until that edge. in_ready is
// high only in IDLE. out_valid and the out_* fields stay stable until the
// edge that sees out_ready high. out_ready has no effect while out_valid is
// low.
//
// HOLD_CYCLES must be in 1..15.
module mux_scan_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_word,
    output logic       in_ready,
    output logic [3:0] mux_a,
    output logic [1:0] mux_s,
    input  logic       mux_result,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       out_valid,
    output logic [3:0] out_word,
    output logic       out_err,
    input  logic       out_ready,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_DWELL = 4'(HOLD_CYCLES - 1);
    localparam logic [1:0] FIRST_IDX  = MSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [1:0] LAST_IDX   = MSB_FIRST ? 2'd0 : 2'd3;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] dwell_q;
    logic [3:0] capture_q;
    logic       sample_now;

    // A sample is taken on the last cycle of the dwell at each select position.
    assign sample_now = (state_q == SCAN) && (dwell_q == LAST_DWELL);
    assign dbg_state  = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the input handshake.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (sample_now && (mux_s == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load the word, step the select, capture bits, publish the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_a     <= 4'd0;
            mux_s     <= 2'd0;
            dwell_q   <= 4'd0;
            capture_q <= 4'd0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= 4'd0;
            out_err   <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mux_a     <= in_word;
                        mux_s     <= FIRST_IDX;
                        dwell_q   <= 4'd0;
                        capture_q <= 4'd0;
                    end
                end
                SCAN: begin
                    if (sample_now) begin
                        capture_q[mux_s] <= mux_result;
                        bit_out          <= mux_result;
                        bit_valid        <= 1'b1;
                        if (mux_s != LAST_IDX) begin
                            mux_s   <= MSB_FIRST ? (mux_s - 2'd1) : (mux_s + 2'd1);
                            dwell_q <= 4'd0;
                        end
                    end else begin
                        dwell_q <= dwell_q + 4'd1;
                    end
                end
                DONE: begin
                    // The first DONE cycle registers the result. After that,
                    // the result stays stable until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_word  <= capture_q;
                        out_err   <= (capture_q != mux_a);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
